round_sequencer: RTL and testbench

Multi-cycle rounding controller for the floating-point result path. It accepts a truncated significand, its two discarded rounding bits, exponent, sign and rounding mode through a start/ready handshake. It decides whether to round up, increments the significand, and renormalizes on carry-out (exponent increment with overflow detection). It sits between the normalizer and the result packer and drives the packer's final sign/exponent/significand.

---
 rtl/round_sequencer_if.sv | 29 ++
 rtl/round_sequencer.sv | 143 ++++++++++++++
 tb/tb_round_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// Handshake and data bundle between the normalizer/packer side and round_sequencer.
// master drives the request; slave is the rounding controller.
interface round_sequencer_if #(
  parameter int SW = 23,
  parameter int EW = 8
);
  logic          start;
  logic [1:0]    round_mode;
  logic          sign_in;
  logic [1:0]    lsbs_in;
  logic [SW-1:0] sgf_in;
  logic [EW-1:0] exp_in;
  logic          busy;
  logic          ready;
  logic [SW-1:0] sgf_out;
  logic [EW-1:0] exp_out;
  logic          sign_out;
  logic          overflow;

  modport master (
    output start, round_mode, sign_in, lsbs_in, sgf_in, exp_in,
    input  busy, ready, sgf_out, exp_out, sign_out, overflow
  );

  modport slave (
    input  start, round_mode, sign_in, lsbs_in, sgf_in, exp_in,
    output busy, ready, sgf_out, exp_out, sign_out, overflow
  );
endinterface

// File: rtl/round_sequencer.sv
// Multi-cycle directed-rounding controller: decide, increment, renormalize, present.
// Optional OVERFLOW_SATURATE_EN: rounding overflow yields max finite instead of infinity.
module round_sequencer #(
  parameter int SW = 23,
  parameter int EW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  round_sequencer_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, DECIDE, INCR, NORM, DONE} state_t;

  state_t        state, state_next;
  logic [1:0]    mode_w;
  logic          sign_w;
  logic [1:0]    lsbs_w;
  logic [SW-1:0] sgf_w, sgf_next;
  logic [EW-1:0] exp_w, exp_next, exp_inc;
  logic          ovf_w, ovf_next;
  logic [SW:0]   sum;
  logic          accept;

  logic          busy_r, ready_r, sign_r, ovf_r;
  logic [SW-1:0] sgf_r;
  logic [EW-1:0] exp_r;

  // Directed rounding only moves away from zero's side that matches the mode;
  // Inf/NaN exponents are never touched.
  function automatic logic round_up(input logic [1:0] mode, input logic sign,
                                    input logic [1:0] lsbs, input logic [EW-1:0] exp);
    logic dir;
    dir = ((mode == 2'b01) && sign) || ((mode == 2'b10) && !sign);
    return dir && (lsbs != 2'b00) && (exp != {EW{1'b1}});
  endfunction

  function automatic logic [SW:0] incr_sgf(input logic [SW-1:0] s);
    return {1'b0, s} + {{SW{1'b0}}, 1'b1};
  endfunction

  function automatic logic [EW-1:0] ovf_exp();
`ifdef OVERFLOW_SATURATE_EN
    return {{(EW-1){1'b1}}, 1'b0};
`else
    return {EW{1'b1}};
`endif
  endfunction

  function automatic logic [SW-1:0] ovf_sgf();
`ifdef OVERFLOW_SATURATE_EN
    return {SW{1'b1}};
`else
    return {SW{1'b0}};
`endif
  endfunction

  assign accept  = (state == IDLE) && bus.start;
  assign sum     = incr_sgf(sgf_w);
  assign exp_inc = exp_w + {{(EW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sgf_next   = sgf_w;
    exp_next   = exp_w;
    ovf_next   = ovf_w;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = DECIDE;
          sgf_next   = bus.sgf_in;
          exp_next   = bus.exp_in;
          ovf_next   = 1'b0;
        end
      end
      DECIDE: state_next = round_up(mode_w, sign_w, lsbs_w, exp_w) ? INCR : DONE;
      INCR: begin
        sgf_next   = sum[SW-1:0];
        state_next = sum[SW] ? NORM : DONE;
      end
      // 1.11..1 + ulp = 10.00..0: fraction clears, exponent bumps
      NORM: begin
        state_next = DONE;
        if (exp_inc == {EW{1'b1}}) begin
          ovf_next = 1'b1;
          exp_next = ovf_exp();
          sgf_next = ovf_sgf();
        end else begin
          exp_next = exp_inc;
          sgf_next = {SW{1'b0}};
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sgf_w <= sgf_next;
    exp_w <= exp_next;
    if (accept) begin
      mode_w <= bus.round_mode;
      sign_w <= bus.sign_in;
      lsbs_w <= bus.lsbs_in;
    end
  end

  // Outputs load on entry to DONE so they are valid alongside the ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_w   <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      sign_r  <= 1'b0;
      ovf_r   <= 1'b0;
      sgf_r   <= {SW{1'b0}};
      exp_r   <= {EW{1'b0}};
    end else begin
      ovf_w   <= ovf_next;
      busy_r  <= (state_next != IDLE);
      ready_r <= (state_next == DONE);
      if (accept) ovf_r <= 1'b0;
      if (state_next == DONE) begin
        sgf_r  <= sgf_next;
        exp_r  <= exp_next;
        sign_r <= sign_w;
        ovf_r  <= ovf_next;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.ready    = ready_r;
  assign bus.sgf_out  = sgf_r;
  assign bus.exp_out  = exp_r;
  assign bus.sign_out = sign_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: directed vectors push expectations,
// a negedge monitor pops and compares on every ready pulse.
module tb_round_sequencer;
  localparam int SW = 23;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  round_sequencer_if #(.SW(SW), .EW(EW)) bus ();

  round_sequencer #(.SW(SW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SW-1:0] sgf;
    logic [EW-1:0] exp;
    logic          sign;
    logic          ovf;
    int            rdy_cyc;
    string         name;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  int rst_req = 0;
  int rst_done = 0;
  bit finish_req = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Monitor: reset-value checks on request, scoreboard pop on each ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_req != rst_done) begin
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_ready",    32'(bus.ready),    32'd0);
      chk("rst_sgf_out",  32'(bus.sgf_out),  32'd0);
      chk("rst_exp_out",  32'(bus.exp_out),  32'd0);
      chk("rst_sign_out", 32'(bus.sign_out), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      rst_done++;
    end
    if (bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_sgf"},     32'(bus.sgf_out),  32'(e.sgf));
        chk({e.name, "_exp"},     32'(bus.exp_out),  32'(e.exp));
        chk({e.name, "_sign"},    32'(bus.sign_out), 32'(e.sign));
        chk({e.name, "_ovf"},     32'(bus.overflow), 32'(e.ovf));
        chk({e.name, "_latency"}, 32'(cyc),          32'(e.rdy_cyc));
        chk({e.name, "_busy"},    32'(bus.busy),     32'd1);
      end
    end
    if (finish_req) begin
      chk("timeouts", 32'(timeouts), 32'd0);
      chk("pending",  32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) timeouts++;
  endtask

  task automatic issue(input string name, input logic [1:0] mode, input logic sign,
                       input logic [1:0] lsbs, input logic [SW-1:0] sgf,
                       input logic [EW-1:0] exp, input logic [SW-1:0] e_sgf,
                       input logic [EW-1:0] e_exp, input logic e_ovf, input int lat,
                       input bit extra_pulse);
    exp_t e;
    @(negedge clk);
    bus.round_mode = mode;
    bus.sign_in    = sign;
    bus.lsbs_in    = lsbs;
    bus.sgf_in     = sgf;
    bus.exp_in     = exp;
    bus.start      = 1'b1;
    e.sgf = e_sgf; e.exp = e_exp; e.sign = sign; e.ovf = e_ovf;
    e.rdy_cyc = cyc + lat;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    if (extra_pulse) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    bus.start = 1'b0; bus.round_mode = 2'b00; bus.sign_in = 1'b0;
    bus.lsbs_in = 2'b00; bus.sgf_in = '0; bus.exp_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_req++;
    @(negedge clk);
    rst = 1'b0;

    issue("trunc",    2'b00, 1'b0, 2'b11, 23'h000005, 8'h80, 23'h000005, 8'h80, 1'b0, 2, 1'b0);
    issue("pinf_pos", 2'b10, 1'b0, 2'b01, 23'h000005, 8'h80, 23'h000006, 8'h80, 1'b0, 3, 1'b0);
    issue("ninf_cry", 2'b01, 1'b1, 2'b10, 23'h7FFFFF, 8'h80, 23'h000000, 8'h81, 1'b0, 4, 1'b0);
`ifdef OVERFLOW_SATURATE_EN
    issue("ovf",      2'b10, 1'b0, 2'b01, 23'h7FFFFF, 8'hFE, 23'h7FFFFF, 8'hFE, 1'b1, 4, 1'b0);
`else
    issue("ovf",      2'b10, 1'b0, 2'b01, 23'h7FFFFF, 8'hFE, 23'h000000, 8'hFF, 1'b1, 4, 1'b0);
`endif
    issue("wrong_dir", 2'b10, 1'b1, 2'b11, 23'h123456, 8'h80, 23'h123456, 8'h80, 1'b0, 2, 1'b0);
    issue("inf_pass",  2'b10, 1'b0, 2'b11, 23'h000001, 8'hFF, 23'h000001, 8'hFF, 1'b0, 2, 1'b0);
    issue("mode11",    2'b11, 1'b1, 2'b11, 23'h0ABCDE, 8'h10, 23'h0ABCDE, 8'h10, 1'b0, 2, 1'b0);
    issue("lsbs_zero", 2'b10, 1'b0, 2'b00, 23'h000007, 8'h40, 23'h000007, 8'h40, 1'b0, 2, 1'b0);
    issue("ninf_inc",  2'b01, 1'b1, 2'b01, 23'h000010, 8'h7F, 23'h000011, 8'h7F, 1'b0, 3, 1'b1);
    issue("trunc_dbl", 2'b00, 1'b1, 2'b10, 23'h000100, 8'h20, 23'h000100, 8'h20, 1'b0, 2, 1'b1);

    // Abort a carry round-up while it sits in INCR.
    @(negedge clk);
    bus.round_mode = 2'b01; bus.sign_in = 1'b1; bus.lsbs_in = 2'b11;
    bus.sgf_in = 23'h7FFFFF; bus.exp_in = 8'h80; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst_req++;
    @(negedge clk);
    rst = 1'b0;
    wait_idle();

    issue("after_rst", 2'b10, 1'b0, 2'b10, 23'h000020, 8'h55, 23'h000021, 8'h55, 1'b0, 3, 1'b0);
    repeat (4) @(negedge clk);
    finish_req = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
